// File: rtl/update_sched_if.sv
// rtl/update_sched_if.sv - requester and graph-container signal bundle for update_sched
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

interface update_sched_if;
    logic                        req0_valid;
    logic                        req0_ready;
    logic [`PRED_WIDTH:0]        req0_src;
    logic [`PRED_WIDTH:0]        req0_dst;
    logic signed [`WEIGHT_WIDTH:0] req0_e;

    logic                        req1_valid;
    logic                        req1_ready;
    logic [`PRED_WIDTH:0]        req1_src;
    logic [`PRED_WIDTH:0]        req1_dst;
    logic signed [`WEIGHT_WIDTH:0] req1_e;

    logic [`PRED_WIDTH:0]        src_cfg;

    logic                        c_reset;
    logic [`PRED_WIDTH:0]        c_src;
    logic [`PRED_WIDTH:0]        c_u_src;
    logic [`PRED_WIDTH:0]        c_u_dst;
    logic signed [`WEIGHT_WIDTH:0] c_u_e;
    logic                        c_done;

    modport master (
        output req0_valid, req0_src, req0_dst, req0_e,
        output req1_valid, req1_src, req1_dst, req1_e,
        output src_cfg, c_done,
        input  req0_ready, req1_ready,
        input  c_reset, c_src, c_u_src, c_u_dst, c_u_e
    );

    modport slave (
        input  req0_valid, req0_src, req0_dst, req0_e,
        input  req1_valid, req1_src, req1_dst, req1_e,
        input  src_cfg, c_done,
        output req0_ready, req1_ready,
        output c_reset, c_src, c_u_src, c_u_dst, c_u_e
    );
endinterface

// File: rtl/update_sched.sv
// rtl/update_sched.sv - two-requester edge-update queue that replays each update through the graph container
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

module update_sched #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                         clk,
    input  logic                         sched_reset,
    update_sched_if.slave                bus,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                  runs_done,
    output logic                         timeout_err
);
    localparam int PW = `PRED_WIDTH + 1;
    localparam int WW = `WEIGHT_WIDTH + 1;
    localparam int EW = 2 * PW + WW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, FIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            prio;
    logic            grant;
    logic            full;
    logic            accept;
    logic            push;
    logic            pop;
    logic            timeout_hit;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;

    // A lone valid requester wins regardless of priority; contention falls back to prio.
    always_comb begin
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end else begin
            grant = prio;
        end
    end

    assign full           = (fifo_count == CW'(DEPTH));
    assign bus.req0_ready = !sched_reset && !full && !grant;
    assign bus.req1_ready = !sched_reset && !full && grant;

    always_comb begin
        if (grant) begin
            accept    = bus.req1_valid && bus.req1_ready;
            push_data = {bus.req1_src, bus.req1_dst, bus.req1_e};
            push      = accept && (bus.req1_src != bus.req1_dst);
        end else begin
            accept    = bus.req0_valid && bus.req0_ready;
            push_data = {bus.req0_src, bus.req0_dst, bus.req0_e};
            push      = accept && (bus.req0_src != bus.req0_dst);
        end
    end

    always_ff @(posedge clk) begin
        if (sched_reset) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~grant;
        end
    end

    always_ff @(posedge clk) begin
        if (sched_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sched_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_count != '0) state_nxt = PULSE;
            PULSE:   state_nxt = WAIT;
            WAIT: begin
                if (bus.c_done) begin
                    state_nxt = FIN;
                end else if (timer == TMAX) begin
                    state_nxt = IDLE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop         = (state == IDLE) && (fifo_count != '0);
        bus.c_reset = sched_reset || (state == PULSE);
        busy        = !sched_reset && (state != IDLE);
        timeout_hit = (state == WAIT) && !bus.c_done && (timer == TMAX);
    end

    // The container operands are captured at pop and held until the run ends.
    always_ff @(posedge clk) begin
        if (sched_reset) begin
            bus.c_src   <= '0;
            bus.c_u_src <= '0;
            bus.c_u_dst <= '0;
            bus.c_u_e   <= '0;
            timer       <= '0;
            runs_done   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                {bus.c_u_src, bus.c_u_dst, bus.c_u_e} <= mem[rd_ptr];
                bus.c_src <= bus.src_cfg;
            end
            if (state == PULSE) begin
                timer <= '0;
            end else if (state == WAIT && timer != TMAX) begin
                timer <= timer + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (state == FIN) begin
                runs_done <= runs_done + 1'b1;
            end
        end
    end
endmodule
